aeg_ctl: RTL
============

// Module: aeg_ctl
// PURPOSE
//  Downstream consumer of the CP instruction decoder. Owns the AEG register file and
//  executes decoded AEG writes/reads, returning read data to the host interface.
//  Dispatches CAEP opcodes to the personality through a start/done handshake.
//  Drives cae_idle/cae_stall and accumulates sticky cae_exception bits.
// PARAMETERS
//  NUM_AEG    16    number of implemented 64-bit AEG registers (1..256)
//  TIMEOUT    4096  max cycles in BUSY before watchdog abort (>=2)
// PORTS
//  clk               in   1            core clock, single clock domain
//  i_reset           in   1            synchronous, active-high reset
//  inst_val          in   1            CAEP dispatch request (decoded)
//  inst_caep         in   5            CAEP opcode index
//  inst_aeg_wr       in   1            AEG write request
//  inst_aeg_rd       in   1            AEG read request
//  inst_aeg_idx      in   18           AEG index for wr/rd
//  err_unimpl        in   1            decoder flagged unimplemented instruction
//  cae_data          in   64           write data, valid with inst_aeg_wr
//  pers_aeg_wr       in   1            personality result write-back strobe
//  pers_aeg_idx      in   8            personality write index
//  pers_aeg_data     in   64           personality write data
//  caep_done         in   1            personality finished current CAEP (pulse)
//  caep_start        out  1            one-cycle CAEP start pulse
//  caep_op           out  5            latched CAEP opcode, stable while busy
//  aeg_q             out  NUM_AEG*64   flattened AEG contents, reg i at [64*i+:64]
//  cae_ret_data_rdy  out  1            read-return strobe
//  cae_ret_data      out  64           read-return data
//  cae_idle          out  1            no CAEP in flight, no request this cycle
//  cae_stall         out  1            CAEP in flight
//  cae_exception     out  16           sticky exception flags
// BEHAVIOUR
//  Reset: all AEG regs 0, caep_start 0, caep_op 0, cae_ret_data_rdy 0, cae_ret_data 0,
//   cae_stall 0, cae_idle 1, cae_exception 0, FSM IDLE, watchdog 0. Reset mid-BUSY aborts, no done needed.
//  Exception bits: [0] UNIMPL (err_unimpl), [1] AEG_RANGE (idx>=NUM_AEG on wr/rd),
//   [2] OVERRUN (inst_val while FSM!=IDLE), [3] TIMEOUT; [15:4] tied 0. Set on edge, cleared only by reset.
//  AEG write: idx<NUM_AEG -> reg[idx]<=cae_data at next edge. Out of range: no write, set bit1.
//  Personality write: pers_aeg_wr with pers_aeg_idx<NUM_AEG updates reg; out of range ignored
//   silently. Same-cycle host and personality write to same idx: host wins.
//  AEG read: latency 1. Cycle after inst_aeg_rd, cae_ret_data_rdy=1 for exactly one cycle,
//   cae_ret_data=reg[idx] (pre-edge value); out of range returns 0 and sets bit1.
//   cae_ret_data holds last value when rdy=0. Write at N, read same idx at N+1 returns new data.
//  AEG wr/rd are serviced in every FSM state (not blocked by stall).
//  FSM: IDLE --inst_val--> START (caep_start=1, caep_op<=inst_caep) --> BUSY
//   --caep_done--> IDLE. caep_done in START also -> IDLE. caep_done in IDLE ignored.
//   BUSY: watchdog counts from 0 each entry; reaching TIMEOUT-1 -> set bit3, -> IDLE.
//   inst_val in START/BUSY dropped, sets bit2, FSM unaffected.
//  cae_stall = (FSM!=IDLE). cae_idle = (FSM==IDLE) & !inst_val & !inst_aeg_wr & !inst_aeg_rd.
//  Watchdog width = $clog2(TIMEOUT); no wrap possible before abort.
// STRUCTURE
//  aeg_ctl_pkg: FSM state enum (IDLE/START/BUSY), exception bit index constants,
//   AEG_W=64, CAEP_W=5.
//  Sub-module aeg_regfile: NUM_AEG x 64 regs, two write ports with fixed priority,
//   one registered read port with range check, flattened q output.
//  aeg_ctl top: dispatch FSM, watchdog counter, exception accumulation.
// TESTING
//  1 Reset, wr idx 3 data 0xDEADBEEF_00000001, rd idx 3 next cycle -> rdy 1 cycle later, data matches, exc=0.
//  2 rd idx NUM_AEG (16) -> rdy pulse, data 0, cae_exception=0x0002; wr idx 20 -> no reg changes.
//  3 inst_val caep 5 -> caep_start 1 cycle, caep_op=5, stall=1 until done after 10 cycles, then idle=1.
//  4 inst_val while BUSY -> exception 0x0004, caep_op unchanged, no second start pulse.
//  5 TIMEOUT=8, no caep_done -> FSM IDLE after 8 BUSY cycles, exception 0x0008, stall 0.
//  6 host and pers write idx 2 same cycle -> reg2=host data; i_reset mid-BUSY -> all outputs reset values.

Source files
------------

// File: rtl/aeg_ctl_pkg.sv
// Shared definitions for the AEG controller slice.
// Contents: datapath widths, exception bit positions and the CAEP dispatch state enum.
package aeg_ctl_pkg;

  localparam int unsigned AEG_W  = 64;
  localparam int unsigned CAEP_W = 5;
  localparam int unsigned EXC_W  = 16;

  // Bit positions in cae_exception; bits above EXC_TIMEOUT are always zero.
  localparam int unsigned EXC_UNIMPL    = 0;
  localparam int unsigned EXC_AEG_RANGE = 1;
  localparam int unsigned EXC_OVERRUN   = 2;
  localparam int unsigned EXC_TIMEOUT   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2
  } state_e;

endpackage

// File: rtl/aeg_regfile.sv
// AEG register file: NUM_AEG x 64-bit registers.
// Ports:
//   clk, i_reset                 clock, synchronous active-high reset
//   host_wr/host_rd/host_idx     host write/read request and shared index
//   host_data                    host write data
//   pers_wr/pers_idx/pers_data   personality write-back port (lower priority)
//   aeg_q                        flattened contents, reg i at [64*i +: 64]
//   rd_rdy/rd_data               registered read return (1-cycle latency)
module aeg_regfile
  import aeg_ctl_pkg::*;
#(
  parameter int unsigned NUM_AEG = 16
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     host_wr,
  input  logic                     host_rd,
  input  logic [17:0]              host_idx,
  input  logic [AEG_W-1:0]         host_data,
  input  logic                     pers_wr,
  input  logic [7:0]               pers_idx,
  input  logic [AEG_W-1:0]         pers_data,
  output logic [NUM_AEG*AEG_W-1:0] aeg_q,
  output logic                     rd_rdy,
  output logic [AEG_W-1:0]         rd_data
);

  logic [AEG_W-1:0] regs_q [NUM_AEG];
  logic [AEG_W-1:0] rd_val;

  // Equality against every implemented index doubles as the range check:
  // an out-of-range index matches nothing, so it neither writes nor reads.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_AEG; i++) begin
      if (host_idx == 18'(i)) rd_val = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_AEG; i++) regs_q[i] <= '0;
      rd_rdy  <= 1'b0;
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_AEG; i++) begin
        if (host_wr && host_idx == 18'(i)) begin
          regs_q[i] <= host_data;
        end else if (pers_wr && pers_idx == 8'(i)) begin
          regs_q[i] <= pers_data;
        end
      end
      rd_rdy <= host_rd;
      if (host_rd) rd_data <= rd_val;
    end
  end

  always_comb begin
    aeg_q = '0;
    for (int i = 0; i < NUM_AEG; i++) aeg_q[AEG_W*i +: AEG_W] = regs_q[i];
  end

endmodule

// File: rtl/aeg_ctl.sv
// AEG controller: owns the AEG register file, services host AEG reads/writes,
// dispatches CAEP opcodes to the personality via start/done with a watchdog,
// and accumulates sticky exception flags.
// Ports:
//   clk, i_reset                          clock, synchronous active-high reset
//   inst_val/inst_caep                    CAEP dispatch request and opcode
//   inst_aeg_wr/inst_aeg_rd/inst_aeg_idx  host AEG access
//   err_unimpl                            decoder unimplemented-instruction flag
//   cae_data                              host write data
//   pers_aeg_wr/pers_aeg_idx/pers_aeg_data personality write-back
//   caep_done                             personality completion pulse
//   caep_start/caep_op                    start pulse and latched opcode
//   aeg_q                                 flattened AEG contents
//   cae_ret_data_rdy/cae_ret_data         read return
//   cae_idle/cae_stall/cae_exception      status
module aeg_ctl
  import aeg_ctl_pkg::*;
#(
  parameter int unsigned NUM_AEG = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     inst_val,
  input  logic [CAEP_W-1:0]        inst_caep,
  input  logic                     inst_aeg_wr,
  input  logic                     inst_aeg_rd,
  input  logic [17:0]              inst_aeg_idx,
  input  logic                     err_unimpl,
  input  logic [AEG_W-1:0]         cae_data,
  input  logic                     pers_aeg_wr,
  input  logic [7:0]               pers_aeg_idx,
  input  logic [AEG_W-1:0]         pers_aeg_data,
  input  logic                     caep_done,
  output logic                     caep_start,
  output logic [CAEP_W-1:0]        caep_op,
  output logic [NUM_AEG*AEG_W-1:0] aeg_q,
  output logic                     cae_ret_data_rdy,
  output logic [AEG_W-1:0]         cae_ret_data,
  output logic                     cae_idle,
  output logic                     cae_stall,
  output logic [EXC_W-1:0]         cae_exception
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WdMax = WD_W'(TIMEOUT - 1);

  state_e          state_q;
  logic [WD_W-1:0] wdog_q;
  logic [3:0]      exc_q;
  logic [3:0]      exc_set;
  logic            host_oor;
  logic            wd_expire;

  aeg_regfile #(
    .NUM_AEG (NUM_AEG)
  ) u_regfile (
    .clk       (clk),
    .i_reset   (i_reset),
    .host_wr   (inst_aeg_wr),
    .host_rd   (inst_aeg_rd),
    .host_idx  (inst_aeg_idx),
    .host_data (cae_data),
    .pers_wr   (pers_aeg_wr),
    .pers_idx  (pers_aeg_idx),
    .pers_data (pers_aeg_data),
    .aeg_q     (aeg_q),
    .rd_rdy    (cae_ret_data_rdy),
    .rd_data   (cae_ret_data)
  );

  assign host_oor = (inst_aeg_idx >= 18'(NUM_AEG));
  // A done arriving in the same cycle as expiry completes normally.
  assign wd_expire = (state_q == StBusy) && !caep_done && (wdog_q == WdMax);

  always_comb begin
    exc_set                = '0;
    exc_set[EXC_UNIMPL]    = err_unimpl;
    exc_set[EXC_AEG_RANGE] = (inst_aeg_wr || inst_aeg_rd) && host_oor;
    exc_set[EXC_OVERRUN]   = inst_val && (state_q != StIdle);
    exc_set[EXC_TIMEOUT]   = wd_expire;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      caep_start <= 1'b0;
      caep_op    <= '0;
      wdog_q     <= '0;
      exc_q      <= '0;
    end else begin
      caep_start <= 1'b0;
      exc_q      <= exc_q | exc_set;
      case (state_q)
        StIdle: begin
          if (inst_val) begin
            state_q    <= StStart;
            caep_start <= 1'b1;
            caep_op    <= inst_caep;
          end
        end
        StStart: begin
          wdog_q  <= '0;
          state_q <= caep_done ? StIdle : StBusy;
        end
        StBusy: begin
          if (caep_done || wd_expire) begin
            state_q <= StIdle;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cae_stall     = (state_q != StIdle);
  assign cae_idle      = (state_q == StIdle) && !inst_val && !inst_aeg_wr && !inst_aeg_rd;
  assign cae_exception = {{(EXC_W - 4){1'b0}}, exc_q};

endmodule
